rgmii_rx_decoder: RTL and testbench
===================================

# rgmii_rx_decoder

Receive-side counterpart of the RGMII transmit path. It takes the RGMII receive pins after the I/O-tile DDR capture, which delivers the rising-edge and falling-edge samples in one clock domain. It rebuilds the GMII byte stream, strips preamble/SFD, checks the Ethernet FCS, and hands the frame payload to the UDP/ARP receive logic. A per-frame completion pulse carries length and error status.

## Interface
Parameters:
- MAX_LEN, 1518, maximum accepted frame length in bytes, DA through FCS inclusive.
- MIN_LEN, 64, minimum accepted frame length in bytes, DA through FCS inclusive.

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- gmii_rx_clk  in  1  receive clock, rising edge only.
- rst  in  1  synchronous active-high reset.
- rx_ctl_r  in  1  RX_CTL sampled on the rising edge (rx_dv).
- rx_ctl_f  in  1  RX_CTL sampled on the falling edge (rx_dv XOR rx_er).
- rxd_r  in  4  RXD sampled on the rising edge (low nibble).
- rxd_f  in  4  RXD sampled on the falling edge (high nibble).
- gmii_rx_dv  out  1  registered GMII data valid.
- gmii_rx_er  out  1  registered GMII receive error.
- gmii_rxd  out  8  registered GMII byte, {rxd_f, rxd_r}.
- pkt_valid  out  1  payload byte strobe, covering DA through FCS.
- pkt_data  out  8  payload byte.
- pkt_sof  out  1  high with the first pkt_valid of a frame.
- frame_done  out  1  one-cycle pulse after the last byte of a frame.
- frame_good  out  1  valid with frame_done; 1 means no error.
- frame_len  out  11  valid with frame_done; byte count DA through FCS, saturating at 2047.
- err_flags  out  4  valid with frame_done; {crc_err, rx_er_seen, runt, oversize}.

## Operation
- Stage 1 registers decode the pins:
  - gmii_rx_dv = rx_ctl_r
  - gmii_rx_er = rx_ctl_r ^ rx_ctl_f
  - gmii_rxd = {rxd_f, rxd_r}
- The FSM runs on the stage-1 signals. States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - dv with byte 0x55 → PREAMBLE.
  - dv with byte 0xD5 → DATA (a PHY that shortens the preamble is tolerated).
  - dv with any other byte → DROP.
- PREAMBLE:
  - 0x55 → stay.
  - 0xD5 → DATA.
  - any other byte → DROP.
  - dv low → IDLE, with no frame_done.
- DATA:
  - Every dv byte → pkt_valid with pkt_data; len increments; CRC updates.
  - The first byte asserts pkt_sof.
  - er while dv → set rx_er_seen.
  - len reaching MAX_LEN+1 → set oversize, go to DROP; that byte is not emitted.
  - dv low → frame_done, then IDLE.
- DROP:
  - No pkt_valid.
  - If entered from DATA, dv low → frame_done with oversize, then IDLE.
  - If entered from IDLE/PREAMBLE, dv low → IDLE silently.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, byte-parallel one byte per clock, reset to init on SFD.
  - Computed over DA through FCS.
  - Good frame residue is 0xDEBB20E3; any other value sets crc_err.
- Status at frame_done:
  - runt = len < MIN_LEN.
  - frame_good = no flag set.
- Carrier extension (dv=0, er=1) is ignored in every state.

## Timing
- Reset values: all outputs 0; FSM in IDLE; CRC 0xFFFFFFFF; len 0.
- gmii_* outputs lag the pins by 1 cycle.
- pkt_valid/pkt_data lag the pins by 2 cycles.
- frame_done occurs 1 cycle after the last pkt_valid.
- pkt_valid is never high in the same cycle as frame_done.
- Back-to-back frames with a minimum IFG of 1 idle cycle are supported; frame_done of frame N precedes pkt_sof of frame N+1.
- Reset asserted mid-frame:
  - Outputs go to 0 on the next edge and no frame_done is emitted.
  - After reset releases with dv still high, the remaining bytes are treated as a new frame in IDLE; non-0x55/0xD5 bytes go to DROP.
- len saturates at 2047 and never wraps.

## Structure
- Shared package (eth_pkg) holds:
  - CRC32_POLY_REFL = 0xEDB88320, CRC32_INIT, CRC32_RESIDUE = 0xDEBB20E3
  - ETH_PREAMBLE = 0x55, ETH_SFD = 0xD5
  - the FSM state encoding
  - the err_flags bit indices
- One sub-module: crc32_d8, a combinational next-CRC function of (crc_in, data_byte), to be reused by the transmit FCS generator.

## Test plan
- Valid frame: 7×0x55, 0xD5, 60-byte payload, correct FCS.
  - 64 pkt_valid; pkt_sof on byte 0.
  - frame_done with frame_good=1, frame_len=64, err_flags=0.
- Same frame with the last FCS byte flipped (XOR 0x01).
  - frame_done with frame_good=0, err_flags=4'b1000.
- Runt: 40 bytes including a correct FCS.
  - frame_len=40, err_flags=4'b0010.
- Oversize: 1530-byte frame.
  - Exactly 1518 pkt_valid; frame_done with err_flags bit0=1, frame_len=1519.
- rx_er pulse (ctl_r=1, ctl_f=0) on byte 20 of a good-length frame.
  - err_flags bit2=1, frame_good=0.
- Back-to-back frames with a 1-cycle IFG.
  - Two frame_done pulses, both good.
- Reset asserted at byte 30 of a frame.
  - All outputs 0 the next cycle; no frame_done.
- Preamble corrupted (0x55, 0x12, …).
  - No pkt_valid and no frame_done.

Source files
------------

// File: rtl/eth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : eth_pkg                                                       |
// | Purpose  : Shared Ethernet constants for the RGMII receive and transmit  |
// |            paths: CRC-32 parameters, preamble/SFD bytes, receive FSM     |
// |            state encoding and err_flags bit positions.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package eth_pkg;

    // Reflected CRC-32 (IEEE 802.3). The residue is the raw register value
    // (no final inversion) after the FCS bytes of an intact frame.
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;

    // Receive framing state machine
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    // err_flags = {crc_err, rx_er_seen, runt, oversize}
    localparam int ERR_W        = 4;
    localparam int ERR_OVERSIZE = 0;
    localparam int ERR_RUNT     = 1;
    localparam int ERR_RXER     = 2;
    localparam int ERR_CRC      = 3;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : crc32_d8                                                      |
// | Purpose  : Combinational byte-parallel reflected CRC-32 step. Shared by  |
// |            the receive FCS checker and the transmit FCS generator.       |
// | Ports    : crc_in    [31:0] current CRC register                         |
// |            data_byte [7:0]  byte to absorb, LSB first on the wire        |
// |            crc_out   [31:0] CRC after absorbing data_byte                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    // Eight unrolled LFSR shifts; synthesis flattens this to an XOR network.
    always_comb begin
        w_crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0] ^ data_byte[i]) begin
                w_crc = (w_crc >> 1) ^ CRC32_POLY_REFL;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign crc_out = w_crc;

endmodule : crc32_d8
`default_nettype wire

// File: rtl/rgmii_rx_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rgmii_rx_decoder                                              |
// | Purpose  : RGMII receive decoder. Rebuilds the GMII byte stream from the |
// |            DDR-captured pins, strips preamble/SFD, checks the FCS and    |
// |            delivers DA..FCS bytes with a per-frame status pulse.         |
// | Ports    : gmii_rx_clk            receive clock (rising edge)            |
// |            rst                    synchronous active-high reset          |
// |            rx_ctl_r / rx_ctl_f    RX_CTL rising / falling samples        |
// |            rxd_r / rxd_f          RXD low / high nibble                  |
// |            gmii_rx_dv/er/rxd      stage-1 GMII signals (1-cycle lag)     |
// |            pkt_valid/data/sof     frame byte stream (2-cycle lag)        |
// |            frame_done             1-cycle end-of-frame pulse             |
// |            frame_good/len/err_flags  status, valid with frame_done       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rgmii_rx_decoder
    import eth_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        rx_ctl_r,
    input  logic        rx_ctl_f,
    input  logic [3:0]  rxd_r,
    input  logic [3:0]  rxd_f,
    output logic        gmii_rx_dv,
    output logic        gmii_rx_er,
    output logic [7:0]  gmii_rxd,
    output logic        pkt_valid,
    output logic [7:0]  pkt_data,
    output logic        pkt_sof,
    output logic        frame_done,
    output logic        frame_good,
    output logic [10:0] frame_len,
    output logic [3:0]  err_flags
);

    localparam logic [10:0] c_len_max  = 11'h7FF;
    localparam logic [10:0] c_over_len = 11'(MAX_LEN + 1);
    localparam logic [10:0] c_min_len  = 11'(MIN_LEN);

    // ------------------------------------------------------------------
    // Stage 1: pin decode
    // ------------------------------------------------------------------
    logic       r_rx_dv;
    logic       r_rx_er;
    logic [7:0] r_rxd;

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            r_rx_dv <= 1'b0;
            r_rx_er <= 1'b0;
            r_rxd   <= 8'h00;
        end else begin
            r_rx_dv <= rx_ctl_r;
            r_rx_er <= rx_ctl_r ^ rx_ctl_f;
            r_rxd   <= {rxd_f, rxd_r};
        end
    end

    // ------------------------------------------------------------------
    // Framing state and per-frame accumulators
    // ------------------------------------------------------------------
    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic [10:0] r_len;
    logic [10:0] w_len_next;
    logic [10:0] w_len_inc;
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;
    logic [31:0] w_crc_upd;
    logic        r_rxer_seen;
    logic        w_rxer_next;
    logic        r_oversize;
    logic        w_oversize_next;
    logic        r_from_data;     // DROP was entered from DATA: owes a frame_done
    logic        w_from_data_next;
    logic        r_first;         // next DATA byte is the first of the frame
    logic        w_first_next;
    logic        w_start;
    logic        w_emit;
    logic        w_sof;
    logic        w_done;
    logic [ERR_W-1:0] w_status;

    crc32_d8 u_crc32_d8 (
        .crc_in    (r_crc),
        .data_byte (r_rxd),
        .crc_out   (w_crc_upd)
    );

    // Length counter sticks at 2047 rather than wrapping.
    assign w_len_inc = (r_len == c_len_max) ? r_len : r_len + 11'd1;

    always_comb begin
        w_status               = '0;
        w_status[ERR_CRC]      = (r_crc != CRC32_RESIDUE);
        w_status[ERR_RXER]     = r_rxer_seen;
        w_status[ERR_RUNT]     = (r_len < c_min_len);
        w_status[ERR_OVERSIZE] = r_oversize;
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= 11'd0;
            r_crc       <= CRC32_INIT;
            r_rxer_seen <= 1'b0;
            r_oversize  <= 1'b0;
            r_from_data <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_len       <= w_len_next;
            r_crc       <= w_crc_next;
            r_rxer_seen <= w_rxer_next;
            r_oversize  <= w_oversize_next;
            r_from_data <= w_from_data_next;
            r_first     <= w_first_next;
        end
    end

    // Next-state and per-cycle strobes. dv low ends the frame whatever er
    // says, so carrier extension (dv=0, er=1) behaves like plain idle.
    always_comb begin
        w_state_next     = r_state;
        w_len_next       = r_len;
        w_crc_next       = r_crc;
        w_rxer_next      = r_rxer_seen;
        w_oversize_next  = r_oversize;
        w_from_data_next = r_from_data;
        w_first_next     = r_first;
        w_start          = 1'b0;
        w_emit           = 1'b0;
        w_sof            = 1'b0;
        w_done           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_rx_dv) begin
                    if (r_rxd == ETH_PREAMBLE) begin
                        w_state_next = ST_PREAMBLE;
                    end else if (r_rxd == ETH_SFD) begin
                        // Short-preamble PHY: SFD straight from idle
                        w_state_next = ST_DATA;
                        w_start      = 1'b1;
                    end else begin
                        w_state_next     = ST_DROP;
                        w_from_data_next = 1'b0;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!r_rx_dv) begin
                    w_state_next = ST_IDLE;
                end else if (r_rxd == ETH_SFD) begin
                    w_state_next = ST_DATA;
                    w_start      = 1'b1;
                end else if (r_rxd != ETH_PREAMBLE) begin
                    w_state_next     = ST_DROP;
                    w_from_data_next = 1'b0;
                end
            end

            ST_DATA: begin
                if (r_rx_dv) begin
                    w_len_next  = w_len_inc;
                    w_rxer_next = r_rxer_seen | r_rx_er;
                    if (w_len_inc == c_over_len) begin
                        // The overflowing byte is swallowed; the rest of
                        // the frame is discarded in DROP.
                        w_oversize_next  = 1'b1;
                        w_from_data_next = 1'b1;
                        w_state_next     = ST_DROP;
                    end else begin
                        w_emit       = 1'b1;
                        w_sof        = r_first;
                        w_first_next = 1'b0;
                        w_crc_next   = w_crc_upd;
                    end
                end else begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (!r_rx_dv) begin
                    w_done           = r_from_data;
                    w_from_data_next = 1'b0;
                    w_state_next     = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // SFD seen: open a fresh frame context.
        if (w_start) begin
            w_len_next       = 11'd0;
            w_crc_next       = CRC32_INIT;
            w_rxer_next      = 1'b0;
            w_oversize_next  = 1'b0;
            w_from_data_next = 1'b0;
            w_first_next     = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers
    // ------------------------------------------------------------------
    logic        r_pkt_valid;
    logic [7:0]  r_pkt_data;
    logic        r_pkt_sof;
    logic        r_frame_done;
    logic        r_frame_good;
    logic [10:0] r_frame_len;
    logic [3:0]  r_err_flags;

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            r_pkt_valid  <= 1'b0;
            r_pkt_data   <= 8'h00;
            r_pkt_sof    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_good <= 1'b0;
            r_frame_len  <= 11'd0;
            r_err_flags  <= 4'd0;
        end else begin
            r_pkt_valid  <= w_emit;
            r_pkt_data   <= w_emit ? r_rxd : 8'h00;
            r_pkt_sof    <= w_sof;
            r_frame_done <= w_done;
            if (w_done) begin
                r_frame_good <= ~|w_status;
                r_frame_len  <= r_len;
                r_err_flags  <= w_status;
            end
        end
    end

    assign gmii_rx_dv = r_rx_dv;
    assign gmii_rx_er = r_rx_er;
    assign gmii_rxd   = r_rxd;
    assign pkt_valid  = r_pkt_valid;
    assign pkt_data   = r_pkt_data;
    assign pkt_sof    = r_pkt_sof;
    assign frame_done = r_frame_done;
    assign frame_good = r_frame_good;
    assign frame_len  = r_frame_len;
    assign err_flags  = r_err_flags;

endmodule : rgmii_rx_decoder
`default_nettype wire

// File: tb/tb_rgmii_rx_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rgmii_rx_decoder                                           |
// | Purpose  : Self-checking bench for rgmii_rx_decoder. Directed frames are |
// |            driven on the RGMII pins; expected bytes and frame status are |
// |            queued as stimulus goes out and compared as the DUT emits.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rgmii_rx_decoder;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    logic        clk;
    logic        rst;
    logic        rx_ctl_r;
    logic        rx_ctl_f;
    logic [3:0]  rxd_r;
    logic [3:0]  rxd_f;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        pkt_valid;
    logic [7:0]  pkt_data;
    logic        pkt_sof;
    logic        frame_done;
    logic        frame_good;
    logic [10:0] frame_len;
    logic [3:0]  err_flags;

    rgmii_rx_decoder #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .gmii_rx_clk (clk),
        .rst         (rst),
        .rx_ctl_r    (rx_ctl_r),
        .rx_ctl_f    (rx_ctl_f),
        .rxd_r       (rxd_r),
        .rxd_f       (rxd_f),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rx_er  (gmii_rx_er),
        .gmii_rxd    (gmii_rxd),
        .pkt_valid   (pkt_valid),
        .pkt_data    (pkt_data),
        .pkt_sof     (pkt_sof),
        .frame_done  (frame_done),
        .frame_good  (frame_good),
        .frame_len   (frame_len),
        .err_flags   (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         sof;
    } byte_exp_t;

    typedef struct {
        bit         good;
        int         len;
        logic [3:0] flags;
        logic [3:0] mask;
    } frame_exp_t;

    byte_exp_t  bq[$];
    frame_exp_t fq[$];

    int n_assert   = 0;
    int n_fail     = 0;
    int pv_count   = 0;
    int done_count = 0;

    logic [31:0] crc_tbl [256];
    logic [31:0] tbl_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [7:0] idx;
        idx = c[7:0] ^ b;
        return crc_tbl[idx] ^ (c >> 8);
    endfunction

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h55 || b == 8'hD5) b = b ^ 8'h01;
        return b;
    endfunction

    task automatic drive(input logic cr, input logic cf, input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_ctl_r = cr;
        rx_ctl_f = cf;
        rxd_r    = b[3:0];
        rxd_f    = b[7:4];
    endtask

    // Drives preamble + SFD + n bytes (DA..FCS) + one trailing IFG cycle.
    task automatic send_frame(input int n, input bit flip_fcs, input int er_idx,
                              input bit corrupt_pre, input bit ext_tail,
                              input bit eg, input int elen,
                              input logic [3:0] eflags, input logic [3:0] emask);
        logic [7:0]  fr[$];
        logic [31:0] c;
        frame_exp_t  fe;
        byte_exp_t   be;
        fr = {};
        c  = 32'hFFFF_FFFF;
        for (int i = 0; i < n - 4; i++) begin
            fr.push_back(rnd_byte());
            c = crc_byte(c, fr[i]);
        end
        c = ~c;
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
        fr.push_back(c[23:16]);
        fr.push_back(c[31:24]);
        if (flip_fcs) fr[n-1] = fr[n-1] ^ 8'h01;
        if (!corrupt_pre) begin
            fe.good = eg; fe.len = elen; fe.flags = eflags; fe.mask = emask;
            fq.push_back(fe);
            for (int i = 0; i < n && i < MAX_LEN; i++) begin
                be.data = fr[i];
                be.sof  = (i == 0);
                bq.push_back(be);
            end
        end
        for (int p = 0; p < 7; p++) drive(1'b1, 1'b1, (corrupt_pre && p == 1) ? 8'h12 : 8'h55);
        drive(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < n; i++) drive(1'b1, (i == er_idx) ? 1'b0 : 1'b1, fr[i]);
        if (ext_tail) drive(1'b0, 1'b1, 8'h0F);
        else          drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((bq.size() != 0 || fq.size() != 0) && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_drain"}, 32'(bq.size() + fq.size()), 32'd0);
    endtask

    // Output scoreboard
    always @(negedge clk) begin
        byte_exp_t  be;
        frame_exp_t fe;
        if (pkt_valid || frame_done)
            check("valid_with_done", {31'd0, pkt_valid & frame_done}, 32'd0);
        if (pkt_valid === 1'b1) begin
            pv_count++;
            if (bq.size() == 0) begin
                check("unexpected_pkt_valid", {24'd0, pkt_data}, 32'hFFFF_FFFF);
            end else begin
                be = bq.pop_front();
                check("pkt_data", {24'd0, pkt_data}, {24'd0, be.data});
                check("pkt_sof", {31'd0, pkt_sof}, {31'd0, be.sof});
            end
            if (pkt_sof === 1'b1)
                check("sof_after_prev_done", 32'(fq.size()), 32'd1);
        end
        if (frame_done === 1'b1) begin
            done_count++;
            if (fq.size() == 0) begin
                check("unexpected_frame_done", {21'd0, frame_len}, 32'hFFFF_FFFF);
            end else begin
                fe = fq.pop_front();
                check("frame_good", {31'd0, frame_good}, {31'd0, fe.good});
                check("frame_len", {21'd0, frame_len}, 32'(fe.len));
                check("err_flags", {28'd0, err_flags & fe.mask}, {28'd0, fe.flags & fe.mask});
            end
        end
    end

    initial begin
        logic [7:0] rf[64];
        byte_exp_t  be;
        frame_exp_t fe;

        for (int i = 0; i < 256; i++) begin
            tbl_c = 32'(i);
            for (int k = 0; k < 8; k++)
                tbl_c = tbl_c[0] ? ((tbl_c >> 1) ^ 32'hEDB8_8320) : (tbl_c >> 1);
            crc_tbl[i] = tbl_c;
        end

        rst = 1'b1; rx_ctl_r = 1'b0; rx_ctl_f = 1'b0; rxd_r = 4'h0; rxd_f = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {11'd0, gmii_rx_dv, gmii_rx_er, gmii_rxd, pkt_valid, pkt_data,
                              pkt_sof, frame_done, frame_good}, 32'd0);
        check("reset_status", {17'd0, frame_len, err_flags}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Stage-1 decode and one-cycle lag, using a carrier-extension pattern
        drive(1'b0, 1'b1, 8'hA5);
        @(negedge clk);
        check("gmii_before_edge", {22'd0, gmii_rx_dv, gmii_rx_er, gmii_rxd}, 32'd0);
        @(negedge clk);
        check("gmii_decode", {22'd0, gmii_rx_dv, gmii_rx_er, gmii_rxd}, {22'd0, 2'b01, 8'hA5});
        drive(1'b1, 1'b1, 8'h3C);
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("gmii_dv_byte", {22'd0, gmii_rx_dv, gmii_rx_er, gmii_rxd}, {22'd0, 2'b10, 8'h3C});
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        wait_drain("idle_glitch");

        // Good 64-byte frame
        pv_count = 0; done_count = 0;
        send_frame(64, 1'b0, -1, 1'b0, 1'b0, 1'b1, 64, 4'b0000, 4'b1111);
        wait_drain("good64");
        check("good64_pv_count", 32'(pv_count), 32'd64);
        check("good64_done_count", 32'(done_count), 32'd1);

        // Corrupted FCS
        send_frame(64, 1'b1, -1, 1'b0, 1'b0, 1'b0, 64, 4'b1000, 4'b1111);
        wait_drain("bad_fcs");

        // Runt with valid FCS
        send_frame(40, 1'b0, -1, 1'b0, 1'b0, 1'b0, 40, 4'b0010, 4'b1111);
        wait_drain("runt");

        // Oversize: byte MAX_LEN+1 is swallowed and the rest dropped
        pv_count = 0; done_count = 0;
        send_frame(1530, 1'b0, -1, 1'b0, 1'b0, 1'b0, MAX_LEN + 1, 4'b0001, 4'b0001);
        wait_drain("oversize");
        check("oversize_pv_count", 32'(pv_count), 32'(MAX_LEN));
        check("oversize_done_count", 32'(done_count), 32'd1);

        // rx_er on byte 20 of a 100-byte frame
        send_frame(100, 1'b0, 20, 1'b0, 1'b0, 1'b0, 100, 4'b0100, 4'b1111);
        wait_drain("rx_er");

        // Back-to-back with a single carrier-extension IFG cycle
        pv_count = 0; done_count = 0;
        send_frame(64, 1'b0, -1, 1'b0, 1'b1, 1'b1, 64, 4'b0000, 4'b1111);
        send_frame(70, 1'b0, -1, 1'b0, 1'b0, 1'b1, 70, 4'b0000, 4'b1111);
        wait_drain("b2b");
        check("b2b_pv_count", 32'(pv_count), 32'd134);
        check("b2b_done_count", 32'(done_count), 32'd2);

        // Corrupted preamble: nothing emitted
        pv_count = 0; done_count = 0;
        send_frame(64, 1'b0, -1, 1'b1, 1'b0, 1'b0, 0, 4'b0000, 4'b0000);
        repeat (10) drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("bad_pre_pv_count", 32'(pv_count), 32'd0);
        check("bad_pre_done_count", 32'(done_count), 32'd0);

        // Reset asserted while byte 30 is on the pins
        pv_count = 0; done_count = 0;
        fe.good = 1'b0; fe.len = 0; fe.flags = 4'b0; fe.mask = 4'b0;
        fq.push_back(fe);
        for (int i = 0; i < 64; i++) rf[i] = rnd_byte();
        for (int i = 0; i < 30; i++) begin
            be.data = rf[i]; be.sof = (i == 0);
            bq.push_back(be);
        end
        for (int p = 0; p < 7; p++) drive(1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, rf[i]);
        drive(1'b1, 1'b1, rf[30]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outputs", {11'd0, gmii_rx_dv, gmii_rx_er, gmii_rxd, pkt_valid, pkt_data,
                                   pkt_sof, frame_done, frame_good}, 32'd0);
        check("midreset_status", {17'd0, frame_len, err_flags}, 32'd0);
        check("midreset_pv_count", 32'(pv_count), 32'd29);
        bq.delete();
        fq.delete();
        drive(1'b1, 1'b1, rf[31]);
        drive(1'b1, 1'b1, rf[32]);
        rst = 1'b0;
        for (int i = 33; i < 64; i++) drive(1'b1, 1'b1, rf[i]);
        repeat (6) drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("postreset_pv_count", 32'(pv_count), 32'd29);
        check("postreset_done_count", 32'(done_count), 32'd0);

        // Recovery: a normal frame after the reset
        pv_count = 0; done_count = 0;
        send_frame(64, 1'b0, -1, 1'b0, 1'b0, 1'b1, 64, 4'b0000, 4'b1111);
        wait_drain("recover");
        check("recover_pv_count", 32'(pv_count), 32'd64);
        check("recover_done_count", 32'(done_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute runtime bound
    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded 500000 ns");
        $fatal(1, "timeout");
    end

endmodule : tb_rgmii_rx_decoder
`default_nettype wire
